keypad_matrix_emulator: RTL and testbench
=========================================

// Module: keypad_matrix_emulator
// PURPOSE
//  Synthesizable 4x4 keypad emulator: responds to the column scan that keypad_input drives and
//  returns row levels as if a physical key were held. Accepts one key-press request at a time over
//  a valid/ready handshake, holds the key for HOLD_CYCLES, releases for GAP_CYCLES, then pulses done.
//  Used for on-board self-test of the calculator datapath without a physical keypad.
// PARAMETERS
//  HOLD_CYCLES    50000  clk cycles the contact stays closed (>=1)
//  GAP_CYCLES     10000  clk cycles of forced release after hold (>=1)
//  BOUNCE_CYCLES  200    bounce window length at press and at release (KEYPAD_BOUNCE_EN only, < HOLD/GAP)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  req_valid  in   1  press request valid
//  req_key    in   4  key code: row index = req_key[3:2], column index = req_key[1:0]
//  req_ready  out  1  high when a request can be accepted
//  col        in   4  scan columns from keypad_input, active-low (0 = column driven)
//  row        out  4  row returns, active-low (0 = pressed key in driven column)
//  busy       out  1  high in PRESS or RELEASE
//  done       out  1  one-cycle pulse on return to IDLE after a completed press
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, req_ready=1, busy=0, done=0, row=4'hF, counters 0.
//  - FSM: IDLE -> PRESS on req_valid&&req_ready (req_key latched that edge; counter=HOLD_CYCLES-1).
//    PRESS: counter decrements each cycle; at 0 -> RELEASE, counter=GAP_CYCLES-1.
//    RELEASE: decrements; at 0 -> IDLE and done=1 for exactly the following cycle.
//  - req_ready = (state==IDLE); requests while busy are not accepted and not queued.
//    done cycle is IDLE: a request in the done cycle is accepted (back-to-back presses legal).
//  - contact = (state==PRESS) [gated by bounce, see CONFIGURATION].
//  - row is combinational from col (passive switch model, zero latency):
//    row[r] = 0 iff contact && r==key_row && col[key_col]==0; all other bits 1.
//  - Multiple low columns: key responds if its own column is among them; no ghosting modelled.
//  - col all-ones or contact=0: row=4'hF.
//  - req_key changes after acceptance are ignored; latched key used for whole press.
//  - Total request-to-done latency: HOLD_CYCLES+GAP_CYCLES+1 cycles from accepting edge.
//  - Reset mid-press: row returns to 4'hF immediately (async), no done pulse, request dropped.
// CONFIGURATION
//  - Macro KEYPAD_BOUNCE_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset,
//    steps every cycle). During first BOUNCE_CYCLES of PRESS, contact = lfsr[0];
//    during first BOUNCE_CYCLES of RELEASE, contact = lfsr[0]; otherwise as without macro.
//  - Macro undefined: LFSR and bounce logic absent; contact clean, exactly as above.
// STRUCTURE
//  - Package calc_kp_pkg: kp_state_t enum {KP_IDLE,KP_PRESS,KP_RELEASE}; kp_key_t (4-bit);
//    functions kp_row_idx(key), kp_col_idx(key); LFSR seed/tap constants.
//  - Sub-module kp_countdown: loadable down-counter (width $clog2(max(HOLD,GAP))),
//    ports clk, reset, load, load_val, zero; instanced once, reloaded at each phase change.
//  - FSM, key latch, bounce LFSR and row decode in this module.
// TESTING (bench uses HOLD_CYCLES=8, GAP_CYCLES=4, BOUNCE_CYCLES=3)
//  1. Reset low with col=4'b1110 -> row=4'hF, req_ready=1, busy=0, done=0.
//  2. req_key=4'h6 accepted; col=4'b1011 -> row=4'b1101 for 8 cycles; col=4'b1110 -> row=4'hF;
//     done pulses 13 cycles after accept edge.
//  3. Scan col 1110,1101,1011,0111 rotating during press of key 4'hF -> row=4'b0111 only while col=0111.
//  4. req_valid held during busy with req_key=4'h2 -> not accepted; accepted in done cycle; second
//     press starts next cycle with key 4'h2.
//  5. Assert reset 3 cycles into PRESS -> row=4'hF same cycle, no done pulse, req_ready=1 after release.
//  6. KEYPAD_BOUNCE_EN: key 4'h0, col=4'b1110 -> row[0] follows lfsr[0] for first 3 PRESS cycles,
//     steady 0 for next 5; first 3 RELEASE cycles follow lfsr[0]; compare to reference LFSR model.

Source files
------------

// File: rtl/calc_kp_pkg.sv
// rtl/calc_kp_pkg.sv - shared types, key-field helpers and LFSR constants for the keypad emulator
package calc_kp_pkg;

  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_PRESS   = 2'd1,
    KP_RELEASE = 2'd2
  } kp_state_t;

  typedef logic [3:0] kp_key_t;

  localparam logic [7:0] KP_LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 map to bits 7,5,4,3 of the shift register
  localparam logic [7:0] KP_LFSR_TAPS = 8'b1011_1000;

  function automatic logic [1:0] kp_row_idx(input kp_key_t key);
    return key[3:2];
  endfunction

  function automatic logic [1:0] kp_col_idx(input kp_key_t key);
    return key[1:0];
  endfunction

  function automatic logic [7:0] kp_lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & KP_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/kp_countdown.sv
// rtl/kp_countdown.sv - loadable down-counter that parks at zero, used for hold and gap phases
module kp_countdown #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - 4x4 keypad emulator: one held key per request, passive row return
// Optional contact bounce at press/release edges is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_matrix_emulator
  import calc_kp_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000,
  parameter int GAP_CYCLES    = 10000,
  parameter int BOUNCE_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
      BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= GAP_CYCLES) begin : g_param_check
    $error("keypad_matrix_emulator: invalid cycle parameters");
  end

  kp_state_t       r_state;
  kp_state_t       w_next_state;
  kp_key_t         r_key;
  logic            r_done;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_zero;
  logic            w_accept;
  logic            w_contact;

  kp_countdown #(.W(CW)) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = HOLD_LOAD;
    w_accept     = 1'b0;
    case (r_state)
      KP_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_load       = 1'b1;
          w_load_val   = HOLD_LOAD;
          w_next_state = KP_PRESS;
        end
      end
      KP_PRESS: begin
        if (w_zero) begin
          w_load       = 1'b1;
          w_load_val   = GAP_LOAD;
          w_next_state = KP_RELEASE;
        end
      end
      KP_RELEASE: begin
        if (w_zero) begin
          w_next_state = KP_IDLE;
        end
      end
      default: w_next_state = KP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= KP_IDLE;
      r_key   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_key <= req_key;
      end
      r_done <= (r_state == KP_RELEASE) && w_zero;
    end
  end

`ifdef KEYPAD_BOUNCE_EN
  localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;

  logic [7:0]    r_lfsr;
  logic [BW-1:0] r_bounce_cnt;

  // Bounce window restarts on every phase load, i.e. at entry to PRESS and to RELEASE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= KP_LFSR_SEED;
      r_bounce_cnt <= '0;
    end else begin
      r_lfsr <= kp_lfsr_next(r_lfsr);
      if (w_load) begin
        r_bounce_cnt <= BW'(BOUNCE_CYCLES);
      end else if (r_bounce_cnt != '0) begin
        r_bounce_cnt <= r_bounce_cnt - 1'b1;
      end
    end
  end

  assign w_contact = (r_state != KP_IDLE && r_bounce_cnt != '0) ? r_lfsr[0]
                                                                 : (r_state == KP_PRESS);
`else
  assign w_contact = (r_state == KP_PRESS);
`endif

  always_comb begin
    row = 4'hF;
    if (w_contact && !col[kp_col_idx(r_key)]) begin
      row[kp_row_idx(r_key)] = 1'b0;
    end
  end

  assign req_ready = (r_state == KP_IDLE);
  assign busy      = (r_state == KP_PRESS) || (r_state == KP_RELEASE);
  assign done      = r_done;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb/tb_keypad_matrix_emulator.sv - directed self-checking bench for keypad_matrix_emulator
// Bounce steps run only when KEYPAD_BOUNCE_EN is defined.
module tb_keypad_matrix_emulator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_key = 4'h0;
  logic       req_ready;
  logic [3:0] col = 4'b1110;
  logic [3:0] row;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [3:0] rot [4];

  always #5 clk = ~clk;

  keypad_matrix_emulator #(
    .HOLD_CYCLES   (8),
    .GAP_CYCLES    (4),
    .BOUNCE_CYCLES (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .done      (done)
  );

`ifdef KEYPAD_BOUNCE_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rot[0] = 4'b1110;
    rot[1] = 4'b1101;
    rot[2] = 4'b1011;
    rot[3] = 4'b0111;

    // 1. reset state
    #1;
    chk("rst_row",   8'(row),       8'h0F);
    chk("rst_ready", 8'(req_ready), 8'h01);
    chk("rst_busy",  8'(busy),      8'h00);
    chk("rst_done",  8'(done),      8'h00);
    tick();
    tick();
    reset = 1'b1;

    // 2. key 6 = row 1, column 2; later req_key change must be ignored
    req_key   = 4'h6;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_key   = 4'h9;
    col       = 4'b1011;
    #1;
    chk("t2_busy",  8'(busy),      8'h01);
    chk("t2_ready", 8'(req_ready), 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("t2_press_row", 8'(row), 8'h0D);
      chk("t2_press_done", 8'(done), 8'h00);
      tick();
    end
    chk("t2_rel_row",  8'(row),  8'h0F);
    chk("t2_rel_busy", 8'(busy), 8'h01);
    col = 4'b1110;
    #1;
    chk("t2_other_col_row", 8'(row), 8'h0F);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rel_done", 8'(done), 8'h00);
      tick();
    end
    chk("t2_done",       8'(done),      8'h01);
    chk("t2_done_ready", 8'(req_ready), 8'h01);
    chk("t2_done_busy",  8'(busy),      8'h00);
    tick();
    chk("t2_done_pulse_end", 8'(done), 8'h00);

    // 3. key F = row 3, column 3 under a rotating scan
    req_key   = 4'hF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      col = rot[i % 4];
      #1;
      chk("t3_scan_row", 8'(row), (rot[i % 4] == 4'b0111) ? 8'h07 : 8'h0F);
      tick();
    end
    repeat (4) tick();
    chk("t3_done", 8'(done), 8'h01);

    // 4. back-to-back: key 5 accepted in the done cycle, key 2 held while busy
    req_key   = 4'h5;
    req_valid = 1'b1;
    tick();
    req_key = 4'h2;
    col     = 4'b1101;
    #1;
    chk("t4_first_key_row", 8'(row),       8'h0D);
    chk("t4_busy_ready",    8'(req_ready), 8'h00);
    repeat (11) tick();
    chk("t4_still_busy", 8'(busy), 8'h01);
    chk("t4_no_done",    8'(done), 8'h00);
    col = 4'b1011;
    #1;
    chk("t4_rel_row", 8'(row), 8'h0F);
    tick();
    chk("t4_done",       8'(done),      8'h01);
    chk("t4_done_ready", 8'(req_ready), 8'h01);
    tick();
    req_valid = 1'b0;
    chk("t4_second_busy", 8'(busy), 8'h01);
    chk("t4_second_row",  8'(row),  8'h0E);
    chk("t4_second_done", 8'(done), 8'h00);
    repeat (12) tick();
    chk("t4_second_done_pulse", 8'(done), 8'h01);
    tick();

    // 5. reset three cycles into a press
    req_key   = 4'h6;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    col       = 4'b1011;
    tick();
    tick();
    chk("t5_pre_rst_row", 8'(row), 8'h0D);
    reset = 1'b0;
    #1;
    chk("t5_rst_row",   8'(row),       8'h0F);
    chk("t5_rst_busy",  8'(busy),      8'h00);
    chk("t5_rst_ready", 8'(req_ready), 8'h01);
    tick();
    tick();
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    chk("t5_no_done",     8'(n_done),    8'h00);
    chk("t5_ready_after", 8'(req_ready), 8'h01);
    chk("t5_row_after",   8'(row),       8'h0F);

`ifdef KEYPAD_BOUNCE_EN
    // 6. bounce windows on key 0 = row 0, column 0
    col       = 4'b1110;
    req_key   = 4'h0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      logic exp_bit;
      if (c <= 3 || (c >= 9 && c <= 11)) exp_bit = ~m_lfsr[0];
      else if (c <= 8)                   exp_bit = 1'b0;
      else                               exp_bit = 1'b1;
      chk("t6_bounce_row", 8'(row), {4'h0, 3'b111, exp_bit});
      tick();
    end
    chk("t6_done", 8'(done), 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
